decode_issue_stage: RTL

//  Decode/issue stage directly upstream of the ALU. Accepts one 32-bit MIPS-style instruction per

---
 rtl/decode_issue_stage_pkg.sv | 61 ++++++
 rtl/decode_issue_stage_regfile_2r1w.sv | 51 +++++
 rtl/decode_issue_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/decode_issue_stage_pkg.sv
// Shared decode constants, instruction field layout and decode helpers
// for the decode/issue stage and its register file.
package decode_issue_stage_pkg;

  localparam int REG_ZERO = 0;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_IMM_MASK = 6'b111000;
  localparam logic [5:0] OP_IMM      = 6'b001000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] raw;
  } instr_f_t;

  function automatic instr_f_t split(input logic [31:0] w);
    instr_f_t f;
    f.opcode = w[OP_LSB +: 6];
    f.rs     = w[RS_LSB +: 5];
    f.rt     = w[RT_LSB +: 5];
    f.rd     = w[RD_LSB +: 5];
    f.shamt  = w[SH_LSB +: 5];
    f.func   = w[5:0];
    f.raw    = w[15:0];
    return f;
  endfunction

  // Register-type writes rd, immediate ALU ops and loads write rt,
  // everything else (stores, branches) has no destination.
  function automatic logic [4:0] dest_of(input instr_f_t f);
    logic [4:0] d;
    d = 5'd0;
    if (f.opcode == OP_RTYPE)
      d = f.rd;
    else if ((f.opcode & OP_IMM_MASK) == OP_IMM
             || f.opcode == OP_LW)
      d = f.rt;
    return d;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW
        || op == OP_BEQ || op == OP_BNE;
  endfunction

endpackage

// File: rtl/decode_issue_stage_regfile_2r1w.sv
// 32-entry register file, two combinational reads, one write port.
// Ports: clk/rst_n, write (we, waddr, wdata), read ports a and b.
module regfile_2r1w
  import decode_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic BYP = (BYPASS != 0);
  localparam logic [4:0] ZERO = 5'(REG_ZERO);

  logic [DATA_W-1:0] mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= '0;
    end else if (we && waddr != ZERO) begin
      mem[waddr] <= wdata;
    end
  end

  // r0 is hard zero, so it is never forwarded either.
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == ZERO)
      rdata_a = '0;
    else if (BYP && we && waddr == raddr_a)
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == ZERO)
      rdata_b = '0;
    else if (BYP && we && waddr == raddr_b)
      rdata_b = wdata;
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one instruction per handshake, reads
// operands with write-back bypass, stalls on RAW via a busy scoreboard
// and presents ALU fields from a one-entry output register.
// Ports: instr valid/ready in, wb write port, flush, ex valid/ready out.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] rt_val,
  output logic [4:0]        shamt,
  output logic [5:0]        func,
  output logic [15:0]       raw_val,
  output logic [4:0]        rd_addr
);

  localparam logic BYP = (BYPASS != 0);
  localparam logic [4:0] ZERO = 5'(REG_ZERO);

  instr_f_t          f;
  logic [4:0]        dest;
  logic              rt_use;
  logic [31:0]       busy;
  logic [31:0]       busy_n;
  logic              haz_rs;
  logic              haz_rt;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] rs_rd;
  logic [DATA_W-1:0] rt_rd;

  assign f      = split(instr);
  assign dest   = dest_of(f);
  assign rt_use = uses_rt(f.opcode);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (f.rs),
    .rdata_a (rs_rd),
    .raddr_b (f.rt),
    .rdata_b (rt_rd)
  );

  // A same-cycle write-back to the source resolves the hazard
  // only when it is forwarded to the read.
  always_comb begin
    haz_rs = f.rs != ZERO && busy[f.rs]
          && !(BYP && wb_en && wb_addr == f.rs);
    haz_rt = rt_use && f.rt != ZERO && busy[f.rt]
          && !(BYP && wb_en && wb_addr == f.rt);
    hazard = haz_rs || haz_rt;
  end

  assign instr_ready = !flush && !hazard
                    && (!ex_valid || ex_ready);
  assign accept = instr_valid && instr_ready;

  // Clears first, then the new destination, so a set
  // overrides a same-index clear.
  always_comb begin
    busy_n = busy;
    if (wb_en)
      busy_n[wb_addr] = 1'b0;
    if (flush && ex_valid && !ex_ready)
      busy_n[rd_addr] = 1'b0;
    if (accept && dest != ZERO)
      busy_n[dest] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      ex_valid <= 1'b0;
      opcode   <= '0;
      rs_val   <= '0;
      rt_val   <= '0;
      shamt    <= '0;
      func     <= '0;
      raw_val  <= '0;
      rd_addr  <= '0;
    end else begin
      busy <= busy_n;
      if (accept) begin
        ex_valid <= 1'b1;
        opcode   <= f.opcode;
        rs_val   <= rs_rd;
        rt_val   <= rt_rd;
        shamt    <= f.shamt;
        func     <= f.func;
        raw_val  <= f.raw;
        rd_addr  <= dest;
      end else if (flush || ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
